ntsc_pix_fetch: RTL
===================

Name: ntsc_pix_fetch

Overview:
- Upstream feeder for the NTSC encoder. Consumes the encoder's pixPosX/pixPosY (640 active X positions, Y = row-20, so Y wraps to 1004..1023 above active) and returns pixCy/pixCu/pixCv.
- Fetches a 320x240 RGB555 framebuffer from VRAM one line ahead into a double line buffer. Horizontally doubles pixels and converts RGB555 to 8-bit YUV with U/V offset 128.

Parameters:
- FB_WIDTH, 320, framebuffer pixels per line; even, <=512.
- FB_HEIGHT, 240, framebuffer lines.
- FB_BASE, 24'h000000, byte address of line 0 pixel 0.
- ADDR_W, 24, VRAM byte address width.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- pixPosX  in  10  encoder horizontal position, 0..639 when active.
- pixPosY  in  10  encoder vertical position; values >= FB_HEIGHT are off-screen.
- pixCy  out  8  luma.
- pixCu  out  8  U + 128.
- pixCv  out  8  V + 128.
- memAddr  out  ADDR_W  VRAM byte address, 4-byte aligned.
- memReq  out  1  read request, held until memAck.
- memAck  in  1  one-cycle acknowledge; memData valid in the same cycle.
- memData  in  32  two pixels; [15:0] = even pixel, [31:16] = odd pixel; bit 15 of each halfword is ignored.
- testPat  in  1  test-pattern select (see Optional Feature).
- fetchBusy  out  1  line fetch in progress.
- fetchErr  out  1  sticky: a fetch trigger arrived while busy.

Behaviour:
- Reset (async, reset=0): all outputs 0 except pixCu=pixCv=128. FSM to IDLE. Buffer contents undefined. fetchErr cleared; reset is the only way to clear it.
- Line buffers: two banks of FB_WIDTH x 15 bits. Line L lives in bank L[0]. Display reads bank pixPosY[0] at index pixPosX[9:1].
- Trigger: fires in the cycle pixPosX==639 is first seen. A registered copy of pixPosX detects the change, so one trigger per line. Target line T = pixPosY+1 (10-bit wrap).
  - If T < FB_HEIGHT: fetch T into bank T[0].
  - Otherwise: no fetch. Y=1023 therefore prefetches line 0.
- FSM states:
  - IDLE: on trigger, latch T, word counter=0, go REQ.
  - REQ: memReq=1, memAddr = FB_BASE + 2*(T*FB_WIDTH) + 4*counter. On memAck, write both pixels to bank indices 2*counter and 2*counter+1, counter+1. After the FB_WIDTH/2-th ack, go IDLE. memAddr/memReq are stable while waiting.
- fetchBusy = (state==REQ).
- Trigger while busy: set fetchErr, abandon the current line, restart from word 0 with the new T. memReq stays high and the new address is presented the next cycle. An ack arriving in the same cycle as the trigger is discarded.
- Display pipeline, latency 3 clocks from pixPosX/pixPosY to pixCy/pixCu/pixCv:
  - Stage 1: register the buffer address and the onscreen flag. onscreen = pixPosY < FB_HEIGHT and pixPosX < 2*FB_WIDTH.
  - Stage 2: buffer read data.
  - Stage 3: convert and register.
  - Off-screen pixels output Y=0, U=V=128.
- Conversion, all in signed 18-bit arithmetic:
  - Expand channels: c8 = {c5, c5[4:2]}.
  - Y = (77R + 150G + 29B + 128) >> 8.
  - U = ((-43R - 85G + 128B + 128) >>> 8) + 128.
  - V = ((128R - 107G - 21B + 128) >>> 8) + 128.
  - Clamp each result to 0..255.
- A write and a read on the same bank/index in the same cycle return the old data. Read-during-write is permitted.

Optional Feature:
- Macro: NTSC_PIXFETCH_TESTPAT_EN.
- Defined: while testPat=1, stage 2 substitutes a colour-bar pixel for buffer data. Bar = pixPosX/80, giving 8 bars: white, yellow, cyan, green, magenta, red, blue, black (RGB555 7FFF, 7FE0, 03FF, 03E0, 7C1F, 7C00, 001F, 0000).
  - Bars pass through the same converter and cover all rows with pixPosY < FB_HEIGHT.
  - Fetch FSM keeps running.
- Undefined: the testPat port exists but is ignored; no bar logic is synthesised.

Decomposition:
- Package ntsc_pkg:
  - Constants: ACTIVE_W=640, BAR_W=80, YUV coefficient constants, black YUV.
  - Fetch-state enum {IDLE, REQ}.
  - Colour-bar RGB555 table.
- One sub-module: rgb555_to_yuv (channel expand, multiply, shift, clamp, output register), instanced as pipeline stage 3.

Test Plan:
- Framebuffer line 0 = 7FFF, pixPosY=0, X sweep -> pixCy=255, pixCu=128, pixCv=128, 3 clocks after each X.
- Pixel 7C00 -> (77, 85, 255), V clamped. Pixel 001F -> (29, 255, 107).
- pixPosY=1023, X reaches 639 -> exactly 160 requests, addresses FB_BASE+0 .. FB_BASE+636 step 4. Random 0-5 cycle ack delay, memReq/memAddr held until ack. fetchBusy falls after the last ack.
- Memory acks slowed to 50 cycles each, two consecutive line ends -> fetchErr=1 after the second trigger. Fetch restarts at the new line's word 0. fetchErr stays set until reset.
- pixPosY=240 and pixPosY=1010 -> no memReq at line end; outputs (0, 128, 128).
- Reset asserted mid-fetch -> memReq=0 and fetchBusy=0 immediately (asynchronous). Outputs (0, 128, 128). With NTSC_PIXFETCH_TESTPAT_EN defined: testPat=1, pixPosX=400 (bar 5, red) -> (77, 85, 255).

Source files
------------

// File: rtl/ntsc_pkg.sv
// Shared constants, fetch-state type and helpers for the NTSC pixel fetcher.
package ntsc_pkg;

  localparam int ACTIVE_W = 640;
  localparam int BAR_W    = 80;

  // BT.601-style luma/chroma weights, scaled by 256
  localparam logic signed [17:0] K_YR =  18'sd77;
  localparam logic signed [17:0] K_YG =  18'sd150;
  localparam logic signed [17:0] K_YB =  18'sd29;
  localparam logic signed [17:0] K_UR = -18'sd43;
  localparam logic signed [17:0] K_UG = -18'sd85;
  localparam logic signed [17:0] K_UB =  18'sd128;
  localparam logic signed [17:0] K_VR =  18'sd128;
  localparam logic signed [17:0] K_VG = -18'sd107;
  localparam logic signed [17:0] K_VB = -18'sd21;
  localparam logic signed [17:0] K_RND = 18'sd128;
  localparam logic signed [17:0] K_OFS = 18'sd128;

  localparam logic [7:0] BLACK_Y = 8'd0;
  localparam logic [7:0] BLACK_U = 8'd128;
  localparam logic [7:0] BLACK_V = 8'd128;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fetch_state_e;

  function automatic logic [14:0] bar_rgb(input logic [2:0] bar);
    case (bar)
      3'd0:    return 15'h7FFF;
      3'd1:    return 15'h7FE0;
      3'd2:    return 15'h03FF;
      3'd3:    return 15'h03E0;
      3'd4:    return 15'h7C1F;
      3'd5:    return 15'h7C00;
      3'd6:    return 15'h001F;
      default: return 15'h0000;
    endcase
  endfunction

  function automatic logic [7:0] clamp8(input logic signed [17:0] v);
    if (v < 18'sd0)        return 8'd0;
    else if (v > 18'sd255) return 8'd255;
    else                   return v[7:0];
  endfunction

endpackage

// File: rtl/rgb555_to_yuv.sv
// RGB555 -> 8-bit YUV converter with output register (display stage 3).
// blank_i forces black; latency 1 clock.
module rgb555_to_yuv
  import ntsc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [14:0] rgb_i,
  input  logic        blank_i,
  output logic [7:0]  y_o,
  output logic [7:0]  u_o,
  output logic [7:0]  v_o
);

  logic signed [17:0] r_s, g_s, b_s;
  logic signed [17:0] y_s, u_s, v_s;

  // 5->8 bit expansion replicates the top bits so full scale maps to 255
  always_comb begin
    r_s = signed'({10'd0, rgb_i[14:10], rgb_i[14:12]});
    g_s = signed'({10'd0, rgb_i[9:5],   rgb_i[9:7]});
    b_s = signed'({10'd0, rgb_i[4:0],   rgb_i[4:2]});
    y_s = (K_YR * r_s + K_YG * g_s + K_YB * b_s + K_RND) >>> 8;
    u_s = ((K_UR * r_s + K_UG * g_s + K_UB * b_s + K_RND) >>> 8) + K_OFS;
    v_s = ((K_VR * r_s + K_VG * g_s + K_VB * b_s + K_RND) >>> 8) + K_OFS;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      y_o <= BLACK_Y;
      u_o <= BLACK_U;
      v_o <= BLACK_V;
    end else if (blank_i) begin
      y_o <= BLACK_Y;
      u_o <= BLACK_U;
      v_o <= BLACK_V;
    end else begin
      y_o <= clamp8(y_s);
      u_o <= clamp8(u_s);
      v_o <= clamp8(v_s);
    end
  end

endmodule

// File: rtl/ntsc_pix_fetch.sv
// Line-ahead VRAM fetcher into a double line buffer plus 3-stage pixel pipeline.
// Optional colour bars on testPat when NTSC_PIXFETCH_TESTPAT_EN is defined.
module ntsc_pix_fetch
  import ntsc_pkg::*;
#(
  parameter int                FB_WIDTH  = 320,
  parameter int                FB_HEIGHT = 240,
  parameter int                ADDR_W    = 24,
  parameter logic [ADDR_W-1:0] FB_BASE   = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [9:0]        pixPosX,
  input  logic [9:0]        pixPosY,
  output logic [7:0]        pixCy,
  output logic [7:0]        pixCu,
  output logic [7:0]        pixCv,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memReq,
  input  logic              memAck,
  input  logic [31:0]       memData,
  input  logic              testPat,
  output logic              fetchBusy,
  output logic              fetchErr
);

  localparam int         WORDS  = FB_WIDTH / 2;
  localparam int         WORD_W = $clog2(WORDS);
  localparam logic [9:0] LAST_X = 10'(ACTIVE_W - 1);
  localparam logic [9:0] FB_H   = 10'(FB_HEIGHT);

  fetch_state_e      state_q, state_d;
  logic [9:0]        posx_q, tgt_q, tgt_d, tgt;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              trig, tgt_ok, wr_en;

  // Edge on pixPosX reaching the last active column: one trigger per line
  assign trig   = (pixPosX == LAST_X) && (posx_q != LAST_X);
  assign tgt    = pixPosY + 10'd1;
  assign tgt_ok = tgt < FB_H;
  assign wr_en  = (state_q == ST_REQ) && memAck && !trig;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (trig) begin
      if (state_q == ST_REQ) err_d = 1'b1;
      if (tgt_ok) begin
        state_d = ST_REQ;
        tgt_d   = tgt;
        cnt_d   = '0;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (wr_en) begin
      cnt_d = cnt_q + WORD_W'(1);
      if (cnt_q == WORD_W'(WORDS - 1)) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      posx_q  <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      posx_q  <= pixPosX;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  logic [ADDR_W-1:0] line_off;
  assign line_off  = ADDR_W'(tgt_q) * ADDR_W'(2 * FB_WIDTH);
  assign memReq    = (state_q == ST_REQ);
  assign memAddr   = memReq ? (FB_BASE + line_off + ADDR_W'({cnt_q, 2'b00})) : '0;
  assign fetchBusy = memReq;
  assign fetchErr  = err_q;

  // Each entry holds an even/odd pixel pair; bank = line parity
  logic [29:0] lbuf_q [2][WORDS];

  always_ff @(posedge clock) begin
    if (wr_en) lbuf_q[tgt_q[0]][cnt_q] <= {memData[30:16], memData[14:0]};
  end

  logic              s1_bank_q, s1_half_q, s1_on_q, s2_on_q;
  logic [WORD_W-1:0] s1_idx_q;
  logic [14:0]       s2_pix_q, pix_d;
  logic [29:0]       rd_word;
  logic              onscreen;
  logic [1:0]        unused_dat;

  assign onscreen   = (pixPosY < FB_H) && ({1'b0, pixPosX} < 11'(2 * FB_WIDTH));
  assign unused_dat = {memData[31], memData[15]};

`ifdef NTSC_PIXFETCH_TESTPAT_EN
  logic       s1_tp_q;
  logic [2:0] s1_bar_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_tp_q  <= 1'b0;
      s1_bar_q <= '0;
    end else begin
      s1_tp_q  <= testPat;
      s1_bar_q <= 3'(pixPosX / 10'(BAR_W));
    end
  end
`else
  logic unused_tp;
  assign unused_tp = testPat;
`endif

  always_comb begin
    rd_word = lbuf_q[s1_bank_q][s1_idx_q];
    pix_d   = s1_half_q ? rd_word[29:15] : rd_word[14:0];
`ifdef NTSC_PIXFETCH_TESTPAT_EN
    if (s1_tp_q) pix_d = bar_rgb(s1_bar_q);
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_bank_q <= 1'b0;
      s1_idx_q  <= '0;
      s1_half_q <= 1'b0;
      s1_on_q   <= 1'b0;
      s2_pix_q  <= '0;
      s2_on_q   <= 1'b0;
    end else begin
      s1_bank_q <= pixPosY[0];
      s1_idx_q  <= WORD_W'(pixPosX[9:2]);
      s1_half_q <= pixPosX[1];
      s1_on_q   <= onscreen;
      s2_pix_q  <= pix_d;
      s2_on_q   <= s1_on_q;
    end
  end

  rgb555_to_yuv u_conv (
    .clk_i   (clock),
    .rst_ni  (reset),
    .rgb_i   (s2_pix_q),
    .blank_i (!s2_on_q),
    .y_o     (pixCy),
    .u_o     (pixCu),
    .v_o     (pixCv)
  );

endmodule
